// File: rtl/pcm_frame_sequencer.sv
// PCM frame sequencer: sync head, timer timestamp, payload bytes.
// Owns the frame FIFO write port and reports frame/overflow status.
module pcm_frame_sequencer #(
  parameter int unsigned HEAD_BYTES  = 4,
  parameter logic [31:0] SYNC_WORD   = 32'hFE6B_2840,
  parameter int unsigned TIM_TIMEOUT = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        sync_i,
  input  logic [15:0] payload_len_i,
  input  logic [7:0]  din_i,
  input  logic        din_valid_i,
  output logic        tim_start_o,
  input  logic [7:0]  tim_data_i,
  input  logic        tim_req_i,
  input  logic        tim_flag_i,
  input  logic        fifo_full_i,
  output logic [7:0]  wr_data_o,
  output logic        wr_req_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic        frame_err_o,
  output logic        ovf_o,
  input  logic        ovf_clr_i,
  output logic [15:0] frame_cnt_o,
  output logic [15:0] drop_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_TIMER,
    S_DATA,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_len;
  logic [15:0] r_cnt;
  logic [31:0] r_tout;
  logic        r_bad;
  logic        r_seen;
  logic        r_tim_start;
  logic        r_wr_req;
  logic [7:0]  r_wr_data;
  logic        r_ovf;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  logic        w_cand;
  logic [7:0]  w_byte;
  logic        w_busy;
  logic        w_done;
  logic        w_ovf_ev;
  logic        w_start;
  logic        w_head_last;
  logic        w_tim_exit;
  logic        w_tim_tout;
  logic        w_data_last;
  logic [7:0]  w_head_byte;
  logic [16:0] w_cnt_inc;

  // byte index 0 is the MSB of the sync word
  assign w_head_byte = 8'(SYNC_WORD >> {~r_cnt[1:0], 3'b000});
  assign w_head_last = (r_cnt == 16'(HEAD_BYTES - 1));
  assign w_tim_exit  = r_seen & ~tim_flag_i;
  assign w_tim_tout  = (r_tout == 32'(TIM_TIMEOUT - 1));
  assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
  assign w_data_last = din_valid_i & (w_cnt_inc == {1'b0, r_len});
  assign w_start     = sync_i & en_i;
  assign w_ovf_ev    = w_cand & fifo_full_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_HEAD;
      S_HEAD:  if (w_head_last) w_next = S_TIMER;
      S_TIMER: begin
        if (w_tim_exit) begin
          w_next = (r_len == 16'd0) ? S_DONE : S_DATA;
        end else if (w_tim_tout) begin
          w_next = S_DONE;
        end
      end
      S_DATA:  if (w_data_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_cand = 1'b0;
    w_byte = 8'hFF;
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
    unique case (r_state)
      S_HEAD: begin
        w_cand = 1'b1;
        w_byte = w_head_byte;
      end
      S_TIMER: begin
        w_cand = tim_req_i;
        w_byte = tim_data_i;
      end
      S_DATA: begin
        w_cand = din_valid_i;
        w_byte = din_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_len       <= '0;
      r_cnt       <= '0;
      r_tout      <= '0;
      r_bad       <= 1'b0;
      r_seen      <= 1'b0;
      r_tim_start <= 1'b0;
      r_wr_req    <= 1'b0;
      r_wr_data   <= 8'hFF;
      r_ovf       <= 1'b0;
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_wr_req    <= w_cand & ~fifo_full_i;
      r_wr_data   <= w_cand ? w_byte : 8'hFF;
      r_tim_start <= (r_state == S_HEAD) & w_head_last;

      // a new overflow beats a simultaneous clear
      if (w_ovf_ev) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end

      if (din_valid_i && (r_state != S_DATA) &&
          (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end

      if (r_state == S_DONE) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len <= payload_len_i;
            r_cnt <= '0;
            r_bad <= 1'b0;
          end
        end
        S_HEAD: begin
          if (w_head_last) begin
            r_cnt  <= '0;
            r_seen <= 1'b0;
            r_tout <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_TIMER: begin
          if (tim_flag_i) r_seen <= 1'b1;
          r_tout <= r_tout + 32'd1;
          if (!w_tim_exit && w_tim_tout) r_bad <= 1'b1;
        end
        S_DATA: begin
          if (din_valid_i) r_cnt <= w_cnt_inc[15:0];
        end
        default: ;
      endcase

      if (w_ovf_ev) r_bad <= 1'b1;
    end
  end

  assign tim_start_o  = r_tim_start;
  assign wr_data_o    = r_wr_data;
  assign wr_req_o     = r_wr_req;
  assign busy_o       = w_busy;
  assign frame_done_o = w_done;
  assign frame_err_o  = w_done & r_bad;
  assign ovf_o        = r_ovf;
  assign frame_cnt_o  = r_frame_cnt;
  assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: doc/pcm_frame_sequencer.md
Name: pcm_frame_sequencer

Overview:
- Frame-level controller for the PCM recording path. On each detected synchronous code it builds one frame into the frame FIFO, in this order: the sync pattern bytes, then the 8-byte decimal timestamp (by starting the timer inserter and forwarding its write stream), then payload_len bytes of PCM data.
- It owns the single FIFO write port. It also reports frame count, overflow and per-frame error status.

Parameters:
- HEAD_BYTES, 4, number of sync pattern bytes emitted (1..4).
- SYNC_WORD, 32'hFE6B_2840, sync pattern; bytes taken MSB first from the top HEAD_BYTES bytes.
- TIM_TIMEOUT, 32, max cycles allowed in TIMER state before abort.

Ports:
- clk_i  in  1  main clock
- rst_n_i  in  1  main reset, asynchronous, active-low
- en_i  in  1  sequencer enable; sampled only in IDLE
- sync_i  in  1  synchronous code detected pulse
- payload_len_i  in  16  payload bytes per frame; latched at frame start
- din_i  in  8  PCM data byte
- din_valid_i  in  1  PCM data byte strobe
- tim_start_o  out  1  one-cycle start pulse to timer inserter
- tim_data_i  in  8  timer inserter write data
- tim_req_i  in  1  timer inserter write request
- tim_flag_i  in  1  timer inserter busy flag
- fifo_full_i  in  1  frame FIFO full
- wr_data_o  out  8  FIFO write data
- wr_req_o  out  1  FIFO write request
- busy_o  out  1  high in any state other than IDLE
- frame_done_o  out  1  one-cycle pulse at frame end
- frame_err_o  out  1  one-cycle pulse with frame_done_o if the frame was bad
- ovf_o  out  1  sticky overflow; cleared only by ovf_clr_i or reset
- ovf_clr_i  in  1  clears ovf_o
- frame_cnt_o  out  16  completed frames, wraps 16'hFFFF->0
- drop_cnt_o  out  16  din bytes ignored outside DATA, saturates at 16'hFFFF

Behaviour:
- Reset values: all outputs 0, except wr_data_o=8'hFF. State=IDLE.
- States: IDLE, HEAD, TIMER, DATA, DONE.
- IDLE -> HEAD when sync_i & en_i.
  - payload_len_i is latched into len_q; byte counter cleared; bad flag cleared.
  - sync_i in any other state is ignored.
- HEAD:
  - Emits HEAD_BYTES byte candidates, one per cycle, MSB first.
  - On the last byte, pulse tim_start_o (same cycle the last byte is registered) and go to TIMER.
- TIMER:
  - Each cycle, forward tim_req_i/tim_data_i as the write candidate.
  - Set seen_q when tim_flag_i=1.
  - Exit when seen_q=1 and tim_flag_i=0 (falling edge): go to DATA, or to DONE if len_q=0.
  - Timeout counter starts at entry. If it reaches TIM_TIMEOUT before exit: set bad, go to DONE.
- DATA:
  - Each din_valid_i cycle is one candidate; byte counter increments.
  - When the counter reaches len_q (last byte registered), go to DONE.
  - No timeout; en_i deassertion does not abort a frame.
- DONE (1 cycle):
  - frame_done_o=1; frame_err_o=bad; frame_cnt_o++.
  - Return to IDLE. A sync_i arriving in DONE is ignored.
- Write port (registered, 1-cycle latency from candidate):
  - wr_req_o = candidate & ~fifo_full_i.
  - wr_data_o = candidate byte when a candidate exists; 8'hFF otherwise.
- Full handling: a candidate arriving while fifo_full_i=1 is discarded, sets bad and sets ovf_o. The frame still runs to completion; counters still advance.
- ovf_o: if a clear and a new overflow happen in the same cycle, the new overflow wins (ovf_o stays 1).
- din_valid_i outside DATA: byte ignored, drop_cnt_o++ (saturating).
- Reset mid-frame returns to IDLE immediately; the partial frame is not counted.

Test Plan:
- HEAD_BYTES=4, len=3, no full. Stimulus: sync_i; timer model emits 8 bytes; then 3 din bytes. Required: wr_req_o high for exactly 15 writes, data sequence FE 6B 28 40, 8 timer bytes, then the 3 din bytes; frame_done_o=1; frame_err_o=0; frame_cnt_o=1.
- len=0. Required: after the timer flag falls, go directly to DONE; 12 writes total; frame_cnt_o increments.
- Timer never raises tim_flag_i. Required: after 32 cycles in TIMER, DONE with frame_err_o=1; 4 writes only.
- fifo_full_i held for 2 cycles during the timer bytes. Required: 2 bytes missing from the write stream, ovf_o=1 and stays 1, frame_err_o=1. ovf_clr_i then drops ovf_o to 0.
- sync_i asserted in DATA plus din_valid_i in IDLE (5 bytes). Required: sync ignored (no restart); drop_cnt_o=5.
- rst_n_i asserted during DATA. Required: all outputs back to reset values at once; frame_cnt_o=0; the next sync starts a clean frame.
